uart_tx_arbiter: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM state encoding,
// default burst/timeout limits and the requester-index width function.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } uart_state_e;

  localparam int DEF_MAX_BURST   = 16;
  localparam int DEF_TIMEOUT_CYC = 1024;

  // Width of an index into n items; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority picker: returns the first set request at or
// after ptr, wrapping modulo N_REQ.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDW = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic             valid,
  output logic [IDW-1:0]   idx
);

  int j;

  // Scan from the farthest slot back to ptr so the nearest set request wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N_REQ;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte sources,
// with bounded bursts. Optional WAIT_BUSY watchdog: define UART_ARB_TIMEOUT_EN.
//
// Handshake: a requester raises req with req_data/req_last stable; the byte is
// taken at the edge the arbiter leaves IDLE (or continues a burst) and ack
// pulses during the following START cycle together with tx_start.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int MAX_BURST   = DEF_MAX_BURST,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int IDW = id_width(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     ack,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [IDW-1:0]       active_id,
  output logic                 idle,
  output logic                 err_timeout,
  output uart_state_e          dbg_state
);

  localparam int BCW = $clog2(MAX_BURST + 1);

  uart_state_e    state, state_next;
  logic [IDW-1:0] ptr;
  logic [BCW-1:0] burst_cnt;
  logic           last_rec;

  logic           pick_valid;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] sel;
  logic [7:0]     sel_byte;
  logic [IDW-1:0] next_after;
  logic           burst_ok;
  logic           to_hit;

  logic           load_grant;
  logic           load_cont;
  logic           rotate;

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign sel        = load_grant ? pick_idx : active_id;
  assign sel_byte   = req_data[{sel, 3'b000} +: 8];
  assign next_after = (active_id == IDW'(N_REQ - 1)) ? '0 : active_id + 1'b1;
  assign burst_ok   = !last_rec && req[active_id] && (burst_cnt < BCW'(MAX_BURST));

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TCW = id_width(TIMEOUT_CYC);
  logic [TCW-1:0] to_cnt;

  // Counts cycles spent in WAIT_BUSY; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT_BUSY) to_cnt <= '0;
    else                           to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit = (to_cnt == TCW'(TIMEOUT_CYC - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_next  = state;
    load_grant  = 1'b0;
    load_cont   = 1'b0;
    rotate      = 1'b0;
    tx_start    = 1'b0;
    ack         = '0;
    err_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          load_grant = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx_start       = 1'b1;
        ack[active_id] = 1'b1;
        state_next     = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (to_hit) begin
          err_timeout = 1'b1;
          rotate      = 1'b1;
          state_next  = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (burst_ok) begin
            load_cont  = 1'b1;
            state_next = START;
          end else begin
            rotate     = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      burst_cnt <= '0;
      tx_data   <= '0;
      active_id <= '0;
      last_rec  <= 1'b0;
    end else begin
      state <= state_next;
      if (load_grant || load_cont) begin
        tx_data  <= sel_byte;
        last_rec <= req_last[sel];
      end
      if (load_grant) active_id <= pick_idx;
      if (tx_start)   burst_cnt <= burst_cnt + 1'b1;
      // Rotation ends the burst: the holder goes to the back of the ring.
      if (rotate) begin
        ptr       <= next_after;
        burst_cnt <= '0;
      end
    end
  end

  assign idle      = (state == IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requesters, a behavioural transmitter and a
// transaction-level round-robin/burst model feeding an expected-grant queue.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N    = 4;
  localparam int MAXB = 4;
  localparam int TO   = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   ack;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic [1:0]     active_id;
  logic           idle;
  logic           err_timeout;
  uart_state_e    dbg_state;

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MAXB), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .req_last    (req_last),
    .ack         (ack),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .active_id   (active_id),
    .idle        (idle),
    .err_timeout (err_timeout),
    .dbg_state   (dbg_state)
  );

  // {last, byte} per requester: rq is what the driver presents, bq a batch being built
  logic [8:0] rq [N][$];
  logic [8:0] bq [N][$];
  logic [9:0] exp_q[$];
  int         checks, failures, m_ptr, err_pulses;
  logic [7:0] cur_data;
  bit         hold_en;
  int         xmit_mode = 0;
  int         fix_rise = 0;
  int         fix_len = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // driver: retire the acked byte, present the head of each queue
  task automatic drive_step();
    logic [8:0] h;
    for (int i = 0; i < N; i++) begin
      if (ack[i] && rq[i].size() != 0) void'(rq[i].pop_front());
      if (rq[i].size() != 0) begin
        h = rq[i][0];
        req[i] = 1'b1;
        req_data[8*i +: 8] = h[7:0];
        req_last[i] = h[8];
      end else begin
        req[i] = 1'b0;
        req_last[i] = 1'b0;
      end
    end
  endtask

  // scoreboard
  task automatic monitor_step();
    logic [9:0]   e;
    logic [N-1:0] one;
    if (err_timeout) err_pulses++;
    if (tx_start || ack != '0) begin
      if (tx_start && exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        one = 4'b0001 << e[9:8];
        chk("grant_id", 32'(active_id), 32'(e[9:8]));
        chk("tx_data", 32'(tx_data), 32'(e[7:0]));
        chk("ack_onehot", 32'(ack), 32'(one));
        cur_data = e[7:0];
      end else begin
        chk("unexpected_start_or_ack", 32'({ack, tx_start}), 32'(0));
      end
    end
    if (tx_busy && hold_en) chk("tx_data_hold", 32'(tx_data), 32'(cur_data));
  endtask

  // Reference: whole batch present at once; serve ring from m_ptr, each turn
  // sends until a last byte, an empty queue, or MAXB bytes.
  task automatic load_batch();
    logic [8:0] mq [N][$];
    logic [8:0] b;
    int id, cnt, j;
    bit found, more;
    for (int i = 0; i < N; i++) begin
      mq[i] = bq[i];
      for (int k = 0; k < bq[i].size(); k++) rq[i].push_back(bq[i][k]);
      bq[i].delete();
    end
    more = 1'b1;
    while (more) begin
      found = 1'b0;
      id = 0;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (!found && mq[j].size() != 0) begin
          found = 1'b1;
          id = j;
        end
      end
      if (!found) begin
        more = 1'b0;
      end else begin
        cnt = 0;
        do begin
          b = mq[id].pop_front();
          exp_q.push_back({2'(id), b[7:0]});
          cnt++;
        end while (!b[8] && mq[id].size() != 0 && cnt < MAXB);
        m_ptr = (id + 1) % N;
      end
    end
  endtask

  task automatic recover();
    exp_q.delete();
    for (int i = 0; i < N; i++) rq[i].delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && idle && !tx_busy && req == '0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 3000), 32'(1));
    if (n >= 3000) recover();
  endtask

  task automatic wait_start(output bit ok);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_start && n < 200);
    ok = tx_start;
    chk("wait_tx_start", 32'(tx_start), 32'(1));
  endtask

  // behavioural transmitter: mode 0 normal, 1 never goes busy, 2 holds off until released
  int rise, len;
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && xmit_mode != 1) begin
        while (xmit_mode == 2) @(negedge clk);
        rise = (fix_rise != 0) ? fix_rise : $urandom_range(1, 3);
        len  = (fix_len != 0) ? fix_len : $urandom_range(2, 6);
        repeat (rise) @(negedge clk);
        tx_busy = 1'b1;
        repeat (len) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    bit ok;
    int n;
    checks = 0; failures = 0; m_ptr = 0; err_pulses = 0;
    cur_data = '0; hold_en = 1'b1;
    req = '0; req_data = '0; req_last = '0;
    rst = 1'b1;
    fork
      forever begin
        @(negedge clk);
        drive_step();
        monitor_step();
      end
    join_none

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_tx_start", 32'(tx_start), 32'(0));
    chk("rst_tx_data", 32'(tx_data), 32'(0));
    chk("rst_active_id", 32'(active_id), 32'(0));
    chk("rst_idle", 32'(idle), 32'(1));
    chk("rst_err", 32'(err_timeout), 32'(0));
    rst = 1'b0;

    // single byte, fixed transmitter timing, one-cycle grant latency
    fix_rise = 2; fix_len = 10;
    @(posedge clk);
    bq[0].push_back({1'b1, 8'h55});
    load_batch();
    @(negedge clk);
    @(negedge clk);
    chk("lat_tx_start", 32'(tx_start), 32'(1));
    chk("lat_tx_data", 32'(tx_data), 32'(8'h55));
    chk("lat_ack", 32'(ack), 32'(4'b0001));
    chk("lat_idle_low", 32'(idle), 32'(0));
    n = 0;
    while (!tx_busy && n < 50) begin @(negedge clk); n++; end
    while (tx_busy && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("idle_after_frame", 32'(idle), 32'(1));
    fix_rise = 0; fix_len = 0;
    wait_done("t1_done");

    // pointer moved past 0: requester 1 must win over 0
    @(posedge clk);
    bq[0].push_back({1'b1, 8'h60});
    bq[1].push_back({1'b1, 8'h61});
    load_batch();
    wait_done("ptr_after_t1");

    // all four requesting, two single-byte messages each
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      bq[i].push_back({1'b1, 8'hB0 + 8'(i)});
      bq[i].push_back({1'b1, 8'hC0 + 8'(i)});
    end
    load_batch();
    wait_done("rr_all");

    // three-byte locked burst from 2 while 0 waits
    @(posedge clk);
    bq[2].push_back({1'b0, 8'hA1});
    bq[2].push_back({1'b0, 8'hA2});
    bq[2].push_back({1'b1, 8'hA3});
    bq[0].push_back({1'b1, 8'h0C});
    load_batch();
    wait_done("burst3");

    // requester 1 never ends its burst: forced rotation to 3 after MAXB bytes
    @(posedge clk);
    for (int k = 0; k < 6; k++) bq[1].push_back({(k == 5), 8'h10 + 8'(k)});
    bq[3].push_back({1'b1, 8'h3F});
    load_batch();
    wait_done("forced_rotation");

    // lock holder drops req mid-burst
    @(posedge clk);
    bq[2].push_back({1'b0, 8'h21});
    bq[2].push_back({1'b0, 8'h22});
    bq[1].push_back({1'b1, 8'h11});
    load_batch();
    wait_done("req_drop");

    // reset while in WAIT_DONE
    @(posedge clk);
    bq[3].push_back({1'b1, 8'h33});
    load_batch();
    n = 0;
    while (dbg_state != WAIT_DONE && n < 100) begin @(negedge clk); n++; end
    chk("reach_wait_done", 32'(dbg_state == WAIT_DONE), 32'(1));
    hold_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ack", 32'(ack), 32'(0));
    chk("mid_rst_tx_start", 32'(tx_start), 32'(0));
    chk("mid_rst_tx_data", 32'(tx_data), 32'(0));
    chk("mid_rst_active_id", 32'(active_id), 32'(0));
    chk("mid_rst_idle", 32'(idle), 32'(1));
    chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    m_ptr = 0;
    exp_q.delete();
    n = 0;
    while (tx_busy && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    hold_en = 1'b1;
    @(posedge clk);
    bq[2].push_back({1'b1, 8'h72});
    bq[1].push_back({1'b1, 8'h71});
    load_batch();
    wait_done("after_mid_rst");

`ifdef UART_ARB_TIMEOUT_EN
    // transmitter never answers: each grant times out and rotates
    xmit_mode = 1;
    @(posedge clk);
    bq[1].push_back({1'b1, 8'h81});
    bq[2].push_back({1'b1, 8'h82});
    load_batch();
    for (int f = 0; f < 2; f++) begin
      wait_start(ok);
      n = 0;
      if (ok) begin
        do begin
          @(negedge clk);
          n++;
        end while (!err_timeout && n < 50);
      end
      chk("timeout_latency", 32'(n), 32'(TO));
      @(negedge clk);
      chk("idle_after_timeout", 32'(idle), 32'(1));
    end
    xmit_mode = 0;
    wait_done("timeout_done");
    chk("err_pulse_count", 32'(err_pulses), 32'(2));
`else
    // without the watchdog WAIT_BUSY waits indefinitely
    xmit_mode = 2;
    @(posedge clk);
    bq[0].push_back({1'b1, 8'h90});
    load_batch();
    wait_start(ok);
    repeat (3 * TO) @(negedge clk);
    chk("no_timeout_state", 32'(dbg_state), 32'(WAIT_BUSY));
    xmit_mode = 0;
    wait_done("no_timeout_done");
`endif

    // randomized batches
    for (int r = 0; r < 25; r++) begin
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
        n = $urandom_range(0, 6);
        for (int k = 0; k < n; k++)
          bq[i].push_back({($urandom_range(0, 3) == 0), 8'($urandom)});
      end
      load_batch();
      wait_done("rand_round");
    end

`ifndef UART_ARB_TIMEOUT_EN
    chk("err_never", 32'(err_pulses), 32'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
